eprisc_bus_arbiter: RTL and testbench

Two-master arbiter and byte sequencer for the 8-bit epRISC system I/O bus (oBusClock / oBusSelect / oBusMOSI / iBusMISO / iBusInterrupt) that links the machine to the I/O controller. It shares the bus between two requesters: port A (core bus unit) and port B (DMA engine). It grants with round-robin fairness and a burst cap. It generates the bus clock, shifts one byte per strobe, and returns the captured MISO byte.

---
 rtl/eprisc_bus_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_eprisc_bus_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eprisc_bus_arbiter.sv
// Two-master round-robin arbiter and byte sequencer for the epRISC system I/O bus.
// Each master port qualifies its request and owns its ack pulse; the top arbitrates and shifts bytes.

module eprisc_bus_port (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic [1:0] sel,
    input  logic       strobe,
    input  logic       own,
    input  logic       done,
    output logic       valid,
    output logic       send,
    output logic       ack
);
    // Device code 0 means "no target", so such a request can never win.
    assign valid = req && (sel != 2'd0);
    assign send  = own && strobe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ack <= 1'b0;
        else        ack <= own && done;
    end
endmodule

module eprisc_bus_arbiter #(
    parameter int CLKDIV   = 2,
    parameter int MAXBURST = 16
) (
    input  logic       iBoardClock,
    input  logic       iBoardReset,
    input  logic       iReqA,
    input  logic       iReqB,
    input  logic [1:0] iSelA,
    input  logic [1:0] iSelB,
    input  logic [7:0] iDataA,
    input  logic [7:0] iDataB,
    input  logic       iStrobeA,
    input  logic       iStrobeB,
    output logic       oGrantA,
    output logic       oGrantB,
    output logic       oAckA,
    output logic       oAckB,
    output logic [7:0] oRxData,
    output logic       oBusIrq,
    output logic       oBusClock,
    output logic [1:0] oBusSelect,
    output logic [7:0] oBusMOSI,
    input  logic [7:0] iBusMISO,
    input  logic       iBusInterrupt
);
    localparam int         NUM_PORTS = 2;
    localparam logic [3:0] DIV_LAST  = 4'(CLKDIV - 1);
    localparam logic [7:0] BURST_CAP = 8'(MAXBURST);

    typedef struct packed {
        logic       req;
        logic [1:0] sel;
        logic       strobe;
        logic [7:0] data;
    } bus_req_t;

    typedef enum logic [2:0] {IDLE, OWN, SETUP, HIGH, TURN} state_t;

    bus_req_t [NUM_PORTS-1:0] rq;
    logic     [NUM_PORTS-1:0] valid, send, own, ack;

    state_t     state, state_next;
    logic       owner, peer, last_grant, pick;
    logic       busy, div_done, byte_done;
    logic [1:0] sel_q;
    logic [3:0] div_cnt;
    logic [7:0] burst_cnt, mosi_q, rx_q;
    logic [1:0] irq_sync;

    assign rq[0] = '{req: iReqA, sel: iSelA, strobe: iStrobeA, data: iDataA};
    assign rq[1] = '{req: iReqB, sel: iSelB, strobe: iStrobeB, data: iDataB};

    assign busy      = (state == OWN) || (state == SETUP) || (state == HIGH);
    assign peer      = ~owner;
    assign div_done  = (div_cnt == DIV_LAST);
    assign byte_done = (state == HIGH) && div_done;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        assign own[i] = busy && (owner == 1'(i));
        eprisc_bus_port u_port (
            .clk    (iBoardClock),
            .rst_n  (iBoardReset),
            .req    (rq[i].req),
            .sel    (rq[i].sel),
            .strobe (rq[i].strobe),
            .own    (own[i]),
            .done   (byte_done),
            .valid  (valid[i]),
            .send   (send[i]),
            .ack    (ack[i])
        );
    end

    // Contention goes to whoever was not granted last; last_grant resets to B so A wins first.
    always_comb begin
        pick = 1'b0;
        if (valid[0] && valid[1]) pick = ~last_grant;
        else if (valid[1])        pick = 1'b1;
    end

    always_ff @(posedge iBoardClock or negedge iBoardReset) begin
        if (!iBoardReset) state <= IDLE;
        else              state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (|valid) state_next = OWN;
            OWN: begin
                if (!rq[owner].req)                                 state_next = TURN;
                else if ((burst_cnt == BURST_CAP) && valid[peer])   state_next = TURN;
                else if (|send)                                     state_next = SETUP;
            end
            SETUP: if (div_done) state_next = HIGH;
            HIGH:  if (div_done) state_next = OWN;
            TURN:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        oBusSelect = 2'd0;
        oBusClock  = 1'b0;
        if (busy) oBusSelect = sel_q;
        if (state == HIGH) oBusClock = 1'b1;
    end

    assign oGrantA  = own[0];
    assign oGrantB  = own[1];
    assign oAckA    = ack[0];
    assign oAckB    = ack[1];
    assign oBusMOSI = mosi_q;
    assign oRxData  = rx_q;
    assign oBusIrq  = irq_sync[1];

    always_ff @(posedge iBoardClock or negedge iBoardReset) begin
        if (!iBoardReset) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            sel_q      <= 2'd0;
            div_cnt    <= 4'd0;
            burst_cnt  <= 8'd0;
            mosi_q     <= 8'd0;
            rx_q       <= 8'd0;
        end else begin
            case (state)
                IDLE: if (|valid) begin
                    owner      <= pick;
                    last_grant <= pick;
                    sel_q      <= rq[pick].sel;
                    burst_cnt  <= 8'd0;
                end
                OWN: begin
                    div_cnt <= 4'd0;
                    if (state_next == SETUP) mosi_q <= rq[owner].data;
                end
                SETUP: div_cnt <= div_done ? 4'd0 : div_cnt + 4'd1;
                HIGH: begin
                    div_cnt <= div_done ? 4'd0 : div_cnt + 4'd1;
                    if (div_done) begin
                        rx_q <= iBusMISO;
                        if (burst_cnt != BURST_CAP) burst_cnt <= burst_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge iBoardClock or negedge iBoardReset) begin
        if (!iBoardReset) irq_sync <= 2'b00;
        else              irq_sync <= {irq_sync[0], iBusInterrupt};
    end
endmodule

// File: tb/tb_eprisc_bus_arbiter.sv
// Directed and randomized bench for eprisc_bus_arbiter; expectations come from the bus timing rules.
module tb_eprisc_bus_arbiter;
    localparam int CLKDIV   = 2;
    localparam int MAXBURST = 4;
    localparam int XFER     = 2 * CLKDIV + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_a = 0, req_b = 0, stb_a = 0, stb_b = 0, irq_in = 0;
    logic [1:0] sel_a = 0, sel_b = 0;
    logic [7:0] dat_a = 0, dat_b = 0, miso = 0;
    logic       grant_a, grant_b, ack_a, ack_b, bus_irq, bus_clk;
    logic [1:0] bus_sel;
    logic [7:0] rx_data, mosi;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_mosi = 0, exp_rx = 0;
    logic [1:0] exp_sel = 0;
    int         rm, rnb, rgap;
    logic [1:0] rsel;

    eprisc_bus_arbiter #(.CLKDIV(CLKDIV), .MAXBURST(MAXBURST)) dut (
        .iBoardClock(clk), .iBoardReset(rst_n),
        .iReqA(req_a), .iReqB(req_b), .iSelA(sel_a), .iSelB(sel_b),
        .iDataA(dat_a), .iDataB(dat_b), .iStrobeA(stb_a), .iStrobeB(stb_b),
        .oGrantA(grant_a), .oGrantB(grant_b), .oAckA(ack_a), .oAckB(ack_b),
        .oRxData(rx_data), .oBusIrq(bus_irq), .oBusClock(bus_clk),
        .oBusSelect(bus_sel), .oBusMOSI(mosi), .iBusMISO(miso),
        .iBusInterrupt(irq_in)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic grant_of(input int m);
        return (m == 0) ? grant_a : grant_b;
    endfunction

    function automatic logic ack_of(input int m);
        return (m == 0) ? ack_a : ack_b;
    endfunction

    task automatic set_req(input int m, input logic r, input logic [1:0] s);
        if (m == 0) begin req_a = r; sel_a = s; end
        else        begin req_b = r; sel_b = s; end
    endtask

    task automatic set_stb(input int m, input logic v, input logic [7:0] d);
        if (m == 0) begin stb_a = v; dat_a = d; end
        else        begin stb_b = v; dat_b = d; end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_grant_a"}, 32'(grant_a), 32'd0);
        chk({tag, "_grant_b"}, 32'(grant_b), 32'd0);
        chk({tag, "_sel"},     32'(bus_sel), 32'd0);
        chk({tag, "_clk"},     32'(bus_clk), 32'd0);
        chk({tag, "_mosi"},    32'(mosi),    32'(exp_mosi));
    endtask

    // One byte from master m, called while m owns the bus in OWN; returns in the ack cycle.
    task automatic xfer(input int m, input logic [7:0] d, input logic [7:0] rx);
        set_stb(m, 1'b1, d);
        miso = rx;
        for (int k = 1; k <= XFER; k++) begin
            tick();
            if (k == 1) begin
                set_stb(m, 1'b0, d);
                chk("xfer_mosi", 32'(mosi), 32'(d));
            end
            chk("xfer_clk",   32'(bus_clk), 32'(k > CLKDIV && k <= 2 * CLKDIV));
            chk("xfer_ack",   32'(ack_of(m)), 32'(k == XFER));
            chk("xfer_ack_o", 32'(ack_of(1 - m)), 32'd0);
            chk("xfer_grant", 32'(grant_of(m)), 32'd1);
            chk("xfer_sel",   32'(bus_sel), 32'(exp_sel));
        end
        chk("xfer_rx", 32'(rx_data), 32'(rx));
        exp_mosi = d;
        exp_rx   = rx;
    endtask

    // Drop m's request in OWN: TURN then IDLE, both with the bus released.
    task automatic release_bus(input int m);
        set_req(m, 1'b0, 2'd0);
        tick();
        chk_idle("rel_turn");
        tick();
        chk_idle("rel_idle");
    endtask

    task automatic do_reset();
        req_a = 0; req_b = 0; stb_a = 0; stb_b = 0; sel_a = 0; sel_b = 0; irq_in = 0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_mosi = 0; exp_rx = 0; exp_sel = 0;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk_idle("rst");
        chk("rst_ack_a", 32'(ack_a), 32'd0);
        chk("rst_ack_b", 32'(ack_b), 32'd0);
        chk("rst_rx",    32'(rx_data), 32'd0);
        chk("rst_irq",   32'(bus_irq), 32'd0);
        rst_n = 1'b1;

        // Single master byte
        set_req(0, 1'b1, 2'd2);
        tick();
        chk("single_grant_a", 32'(grant_a), 32'd1);
        chk("single_sel", 32'(bus_sel), 32'd2);
        exp_sel = 2'd2;
        xfer(0, 8'hA5, 8'h3C);
        release_bus(0);

        // Simultaneous requests from reset: A first, then B, then A again
        do_reset();
        set_req(0, 1'b1, 2'd1);
        set_req(1, 1'b1, 2'd3);
        tick();
        chk("arb_grant_a", 32'(grant_a), 32'd1);
        chk("arb_grant_b", 32'(grant_b), 32'd0);
        chk("arb_sel_a", 32'(bus_sel), 32'd1);
        release_bus(0);
        tick();
        chk("arb_grant_b2", 32'(grant_b), 32'd1);
        chk("arb_sel_b", 32'(bus_sel), 32'd3);
        set_req(0, 1'b1, 2'd1);
        tick();
        chk("arb_b_keeps", 32'(grant_b), 32'd1);
        release_bus(1);
        tick();
        chk("arb_grant_a2", 32'(grant_a), 32'd1);
        chk("arb_sel_a2", 32'(bus_sel), 32'd1);
        release_bus(0);

        // Burst cap with B pending
        do_reset();
        set_req(0, 1'b1, 2'd1);
        set_req(1, 1'b1, 2'd2);
        tick();
        exp_sel = 2'd1;
        chk("cap_grant_a", 32'(grant_a), 32'd1);
        for (int i = 0; i < MAXBURST; i++) xfer(0, 8'(8'h10 + i), 8'(8'h80 + i));
        tick();
        chk_idle("cap_turn");
        tick();
        chk_idle("cap_idle");
        tick();
        chk("cap_grant_b", 32'(grant_b), 32'd1);
        chk("cap_sel_b", 32'(bus_sel), 32'd2);
        exp_sel = 2'd2;
        xfer(1, 8'hB1, 8'h1B);
        release_bus(1);
        tick();
        chk("cap_regrant_a", 32'(grant_a), 32'd1);
        exp_sel = 2'd1;
        xfer(0, 8'h15, 8'h85);
        xfer(0, 8'h16, 8'h86);
        release_bus(0);

        // Burst cap with B idle: no yield
        do_reset();
        set_req(0, 1'b1, 2'd3);
        tick();
        exp_sel = 2'd3;
        for (int i = 0; i < 6; i++) xfer(0, 8'(8'h20 + i), 8'(8'h60 + i));
        tick();
        chk("nocap_grant_a", 32'(grant_a), 32'd1);
        release_bus(0);

        // Invalid and ignored inputs
        do_reset();
        set_req(1, 1'b1, 2'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("sel0_grant_b", 32'(grant_b), 32'd0);
            chk("sel0_sel", 32'(bus_sel), 32'd0);
        end
        set_req(0, 1'b1, 2'd3);
        tick();
        chk("inv_grant_a", 32'(grant_a), 32'd1);
        exp_sel = 2'd3;
        xfer(0, 8'h5A, 8'hC3);
        sel_a = 2'd1;
        set_stb(1, 1'b1, 8'hFF);
        tick();
        set_stb(1, 1'b0, 8'hFF);
        chk("bstb_mosi", 32'(mosi), 32'h5A);
        chk("bstb_sel_held", 32'(bus_sel), 32'd3);
        for (int k = 0; k < XFER; k++) begin
            tick();
            chk("bstb_ack_b", 32'(ack_b), 32'd0);
            chk("bstb_clk", 32'(bus_clk), 32'd0);
        end
        set_req(0, 1'b0, 2'd1);
        set_stb(0, 1'b1, 8'h77);
        tick();
        set_stb(0, 1'b0, 8'h77);
        chk_idle("drop_stb");
        for (int k = 0; k < XFER; k++) begin
            tick();
            chk("drop_ack_a", 32'(ack_a), 32'd0);
            chk_idle("drop_after");
        end
        set_req(1, 1'b0, 2'd0);

        // Reset mid-byte
        set_req(0, 1'b1, 2'd2);
        tick();
        exp_sel = 2'd2;
        chk("mid_grant_a", 32'(grant_a), 32'd1);
        set_stb(0, 1'b1, 8'h99);
        miso = 8'h11;
        tick();
        set_stb(0, 1'b0, 8'h99);
        for (int k = 2; k <= CLKDIV + 1; k++) tick();
        chk("mid_clk_high", 32'(bus_clk), 32'd1);
        rst_n = 1'b0;
        #1;
        exp_mosi = 0; exp_rx = 0;
        chk_idle("mid_rst");
        chk("mid_rst_ack", 32'(ack_a), 32'd0);
        chk("mid_rst_rx", 32'(rx_data), 32'd0);
        tick();
        chk("mid_rst_ack2", 32'(ack_a), 32'd0);
        set_req(0, 1'b1, 2'd1);
        set_req(1, 1'b1, 2'd2);
        rst_n = 1'b1;
        tick();
        chk("post_rst_grant_a", 32'(grant_a), 32'd1);
        chk("post_rst_sel", 32'(bus_sel), 32'd1);
        exp_sel = 2'd1;
        xfer(0, 8'h42, 8'h24);
        set_req(1, 1'b0, 2'd0);
        release_bus(0);

        // Interrupt synchronizer
        irq_in = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 3) irq_in = 1'b0;
            chk("irq", 32'(bus_irq), 32'(k >= 2 && k <= 4));
        end

        // Randomized single-owner bursts
        for (int t = 0; t < 12; t++) begin
            rm   = int'($urandom_range(0, 1));
            rnb  = int'($urandom_range(1, 3));
            rgap = int'($urandom_range(0, 2));
            rsel = 2'($urandom_range(1, 3));
            set_req(rm, 1'b1, rsel);
            tick();
            chk("rnd_grant", 32'(grant_of(rm)), 32'd1);
            chk("rnd_grant_o", 32'(grant_of(1 - rm)), 32'd0);
            chk("rnd_sel", 32'(bus_sel), 32'(rsel));
            exp_sel = rsel;
            for (int b = 0; b < rnb; b++) xfer(rm, 8'($urandom), 8'($urandom));
            release_bus(rm);
            for (int g = 0; g < rgap; g++) begin
                tick();
                chk_idle("rnd_gap");
                chk("rnd_gap_rx", 32'(rx_data), 32'(exp_rx));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
